// File: rtl/sraml_bus_arbiter_if.sv
// SRAM-like channel bundle: request fields driven by the master side,
// address/data handshakes and read data returned by the slave side.
interface sraml_bus_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sraml_bus_arbiter.sv
// Two-to-one SRAM-like arbiter sharing one downstream port between the
// instruction and data channels; data first, with a bounded data win streak.
module sraml_bus_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    sraml_bus_arbiter_if.slave         inst_if,
    sraml_bus_arbiter_if.slave         data_if,
    sraml_bus_arbiter_if.master        bus_if,
    output logic                       busy,
    output logic                       owner
);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic       owner_q, owner_d;
    logic [3:0] streak_q, streak_d;

    logic any_req;
    logic contested;
    logic win_data;
    logic sel_data;
    logic granted;

    always_comb begin
        any_req   = inst_if.req | data_if.req;
        contested = inst_if.req & data_if.req;
        win_data  = data_if.req & (~inst_if.req | (streak_q < STREAK_MAX));
        // In IDLE the live winner steers the bus; afterwards the locked owner does.
        sel_data  = (state_q == IDLE) ? win_data : owner_q;
        granted   = (state_q == REQ) | ((state_q == IDLE) & any_req);
    end

    assign bus_if.req   = (state_q == WAIT) ? 1'b0 : (sel_data ? data_if.req : inst_if.req);
    assign bus_if.wr    = sel_data ? data_if.wr    : inst_if.wr;
    assign bus_if.size  = sel_data ? data_if.size  : inst_if.size;
    assign bus_if.addr  = sel_data ? data_if.addr  : inst_if.addr;
    assign bus_if.wdata = sel_data ? data_if.wdata : inst_if.wdata;

    assign inst_if.addr_ok = granted & ~sel_data & bus_if.addr_ok;
    assign data_if.addr_ok = granted &  sel_data & bus_if.addr_ok;

    // A data_ok outside WAIT belongs to no live transaction and is dropped.
    assign inst_if.data_ok = (state_q == WAIT) & ~owner_q & bus_if.data_ok;
    assign data_if.data_ok = (state_q == WAIT) &  owner_q & bus_if.data_ok;

    assign inst_if.rdata = bus_if.rdata;
    assign data_if.rdata = bus_if.rdata;

    assign busy  = (state_q != IDLE);
    assign owner = owner_q;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        streak_d = streak_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = win_data;
                    // A contested data win only happens below the limit, so +1 saturates.
                    if (win_data && contested) begin
                        streak_d = streak_q + 4'd1;
                    end else if (!win_data) begin
                        streak_d = 4'd0;
                    end
                    state_d = bus_if.addr_ok ? WAIT : REQ;
                end
            end
            REQ: begin
                if (bus_if.addr_ok) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus_if.data_ok) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            streak_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
        end
    end
endmodule

// File: tb/tb_sraml_bus_arbiter.sv
// Bench for sraml_bus_arbiter: directed scenarios plus randomized traffic,
// all checked each cycle against a transaction-level model of the arbiter.
module tb_sraml_bus_arbiter;
    localparam int MAXS = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    logic owner;

    sraml_bus_arbiter_if ib();
    sraml_bus_arbiter_if db();
    sraml_bus_arbiter_if bb();

    sraml_bus_arbiter #(.MAX_DATA_STREAK(MAXS)) dut (
        .clk     (clk),
        .rst     (rst),
        .inst_if (ib),
        .data_if (db),
        .bus_if  (bb),
        .busy    (busy),
        .owner   (owner)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: 0 = free, 1 = address phase pending, 2 = awaiting read data/ack
    int m_phase  = 0;
    bit m_owner  = 1'b0;
    int m_streak = 0;
    bit e_sel    = 1'b0;
    bit e_iaok   = 1'b0;
    bit e_daok   = 1'b0;

    bit logging = 1'b0;
    bit grant_log[$];

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_owner  = 1'b0;
        m_streak = 0;
    endtask

    // Settle, then compare every DUT output against the model for this cycle.
    task automatic eval();
        logic e_req, e_idok, e_ddok, fields;
        #3;
        e_req  = 1'b0;
        e_idok = 1'b0;
        e_ddok = 1'b0;
        fields = 1'b0;
        e_sel  = m_owner;
        e_iaok = 1'b0;
        e_daok = 1'b0;
        if (m_phase == 0) begin
            if (ib.req || db.req) begin
                e_sel  = db.req && (!ib.req || m_streak < MAXS);
                fields = 1'b1;
            end
        end else if (m_phase == 1) begin
            fields = 1'b1;
        end else begin
            e_idok = bb.data_ok && !m_owner;
            e_ddok = bb.data_ok && m_owner;
        end
        if (fields) begin
            e_req  = e_sel ? db.req : ib.req;
            e_iaok = bb.addr_ok && !e_sel;
            e_daok = bb.addr_ok && e_sel;
            chk1 ("bus_wr",    bb.wr,    e_sel ? db.wr    : ib.wr);
            chk32("bus_size",  {30'd0, bb.size}, {30'd0, e_sel ? db.size : ib.size});
            chk32("bus_addr",  bb.addr,  e_sel ? db.addr  : ib.addr);
            chk32("bus_wdata", bb.wdata, e_sel ? db.wdata : ib.wdata);
        end
        chk1 ("bus_req",      bb.req,     e_req);
        chk1 ("inst_addr_ok", ib.addr_ok, e_iaok);
        chk1 ("data_addr_ok", db.addr_ok, e_daok);
        chk1 ("inst_data_ok", ib.data_ok, e_idok);
        chk1 ("data_data_ok", db.data_ok, e_ddok);
        chk32("inst_rdata",   ib.rdata,   bb.rdata);
        chk32("data_rdata",   db.rdata,   bb.rdata);
        chk1 ("busy",         busy,       m_phase != 0);
        chk1 ("owner",        owner,      m_owner);
        if (logging) begin
            if (ib.addr_ok) grant_log.push_back(1'b0);
            if (db.addr_ok) grant_log.push_back(1'b1);
        end
    endtask

    // Apply this cycle's inputs to the model, then move to the next cycle.
    task automatic adv();
        if (!rst) begin
            model_reset();
        end else begin
            case (m_phase)
                0: begin
                    if (ib.req || db.req) begin
                        if (e_sel && ib.req) m_streak = (m_streak + 1 > MAXS) ? MAXS : m_streak + 1;
                        else if (!e_sel) m_streak = 0;
                        m_owner = e_sel;
                        m_phase = bb.addr_ok ? 2 : 1;
                    end
                end
                1: if (bb.addr_ok) m_phase = 2;
                default: if (bb.data_ok) m_phase = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    bit exp_order[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        ib.req = 0; ib.wr = 0; ib.size = 0; ib.addr = 0; ib.wdata = 0;
        db.req = 0; db.wr = 0; db.size = 0; db.addr = 0; db.wdata = 0;
        bb.addr_ok = 0; bb.data_ok = 0; bb.rdata = 0;
        model_reset();
        @(posedge clk);
        #1;

        // Power-on reset
        eval();
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_owner", owner, 1'b0);
        chk1("reset_bus_req", bb.req, 1'b0);
        adv();
        rst = 1'b1;

        // Single inst read with immediate address handshake
        ib.req = 1; ib.wr = 0; ib.size = 2; ib.addr = 32'hBFC00000;
        bb.addr_ok = 1;
        eval();
        chk32("t_inst_bus_addr", bb.addr, 32'hBFC00000);
        chk1("t_inst_aok", ib.addr_ok, 1'b1);
        chk1("t_inst_data_aok", db.addr_ok, 1'b0);
        adv();
        ib.req = 0; bb.addr_ok = 0; bb.data_ok = 1; bb.rdata = 32'h3C080001;
        eval();
        chk1("t_inst_dok", ib.data_ok, 1'b1);
        chk32("t_inst_rdata", ib.rdata, 32'h3C080001);
        chk1("t_inst_data_dok", db.data_ok, 1'b0);
        adv();
        bb.data_ok = 0;

        // Data write with a delayed address handshake
        db.req = 1; db.wr = 1; db.size = 2; db.addr = 32'h80001000; db.wdata = 32'h12345678;
        eval();
        chk1("t_wr_bus_wr", bb.wr, 1'b1);
        chk32("t_wr_bus_size", {30'd0, bb.size}, 32'd2);
        chk32("t_wr_bus_addr", bb.addr, 32'h80001000);
        chk32("t_wr_bus_wdata", bb.wdata, 32'h12345678);
        adv();
        bb.addr_ok = 1;
        eval();
        chk1("t_wr_data_aok", db.addr_ok, 1'b1);
        chk32("t_wr_bus_addr_req", bb.addr, 32'h80001000);
        adv();
        db.req = 0; bb.addr_ok = 0;
        eval();
        chk1("t_wr_dok_early", db.data_ok, 1'b0);
        chk1("t_wr_busy_wait", busy, 1'b1);
        adv();
        bb.data_ok = 1;
        eval();
        chk1("t_wr_dok", db.data_ok, 1'b1);
        adv();
        bb.data_ok = 0;

        // Continuous contention: addr_ok immediately, data_ok the next cycle
        ib.req = 1; ib.wr = 0; ib.size = 2; ib.addr = 32'h00400000;
        db.req = 1; db.wr = 0; db.size = 2; db.addr = 32'h80000040;
        bb.addr_ok = 1; bb.data_ok = 1;
        logging = 1'b1;
        for (int c = 0; c < 20; c++) begin
            eval();
            adv();
        end
        logging = 1'b0;
        ib.req = 0; db.req = 0; bb.addr_ok = 0; bb.data_ok = 0;
        chk32("contention_grants", 32'(grant_log.size()), 32'd10);
        for (int g = 0; g < 10; g++) begin
            if (g < grant_log.size()) chk1("contention_order", grant_log[g], exp_order[g]);
        end

        // Grant lock while address handshake is withheld
        db.req = 1; db.wr = 0; db.size = 2; db.addr = 32'h80002000;
        eval();
        adv();
        ib.req = 1; ib.addr = 32'h00400010;
        for (int c = 0; c < 3; c++) begin
            eval();
            chk32("lock_bus_addr", bb.addr, 32'h80002000);
            chk1("lock_owner", owner, 1'b1);
            chk1("lock_inst_aok", ib.addr_ok, 1'b0);
            adv();
        end
        bb.addr_ok = 1;
        eval();
        chk1("lock_data_aok", db.addr_ok, 1'b1);
        adv();
        db.req = 0; bb.addr_ok = 0; bb.data_ok = 1;
        eval();
        adv();
        bb.data_ok = 0; bb.addr_ok = 1;
        eval();
        chk1("lock_inst_after", ib.addr_ok, 1'b1);
        adv();
        ib.req = 0; bb.addr_ok = 0; bb.data_ok = 1;
        eval();
        adv();
        bb.data_ok = 0;

        // Reset in WAIT, then a late data_ok from the aborted transaction
        db.req = 1; db.addr = 32'h80003000; bb.addr_ok = 1;
        eval();
        adv();
        db.req = 0; bb.addr_ok = 0;
        eval();
        chk1("rst_pre_owner", owner, 1'b1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk1("rst_async_busy", busy, 1'b0);
        chk1("rst_async_owner", owner, 1'b0);
        @(posedge clk);
        #1;
        eval();
        adv();
        rst = 1'b1;
        eval();
        adv();
        eval();
        adv();
        bb.data_ok = 1;
        eval();
        chk1("stray_inst_dok", ib.data_ok, 1'b0);
        chk1("stray_data_dok", db.data_ok, 1'b0);
        chk1("stray_busy", busy, 1'b0);
        adv();
        bb.data_ok = 0;
        eval();
        chk1("stray_busy_after", busy, 1'b0);
        adv();

        // Randomized traffic; masters hold requests until their addr_ok
        e_iaok = 1'b0;
        e_daok = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (!ib.req || e_iaok) begin
                ib.req   = ($urandom_range(0, 9) < 4);
                ib.wr    = 1'($urandom_range(0, 1));
                ib.size  = 2'($urandom_range(0, 2));
                ib.addr  = $urandom;
                ib.wdata = $urandom;
            end
            if (!db.req || e_daok) begin
                db.req   = ($urandom_range(0, 9) < 5);
                db.wr    = 1'($urandom_range(0, 1));
                db.size  = 2'($urandom_range(0, 2));
                db.addr  = $urandom;
                db.wdata = $urandom;
            end
            bb.addr_ok = ($urandom_range(0, 2) != 0);
            bb.data_ok = 1'($urandom_range(0, 1));
            bb.rdata   = $urandom;
            eval();
            adv();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
